// File: rtl/spi_regbus_slave.sv
// SPI mode-0 slave that turns each 24-bit {addr, data} frame into one register
// write followed by a readback of the same address. The readback is then shifted
// out on MISO during the next frame.
module spi_regbus_slave #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2     // must be >= 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              frame_err
);

    localparam int unsigned FRAME_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT,
        S_FETCH,
        S_LOAD
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sclk_prev_q;

    logic [FRAME_W-1:0] rx_sr_q,   rx_sr_d;
    logic [FRAME_W-1:0] tx_sr_q,   tx_sr_d;
    logic [FRAME_W-1:0] tx_hold_q, tx_hold_d;   // last loaded readback, restored on a bad frame
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               ovf_q,     ovf_d;
    logic               armed_q,   armed_d;     // set once cs_n has been seen high after reset
    logic [ADDR_W-1:0]  bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic               bus_we_q,    bus_we_d;
    logic               bus_re_q,    bus_re_d;
    logic               frame_err_q, frame_err_d;

    logic sclk_s;
    logic mosi_s;
    logic csn_s;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    assign spi_miso  = ~csn_s & tx_sr_q[FRAME_W-1];
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign frame_err = frame_err_q;

    // Synchronise the SPI pins into sys_clk; cs_n resets low so a select held
    // through reset cannot arm the slave before it is genuinely seen high.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_q <= sclk_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            tx_hold_q   <= '0;
            bit_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            armed_q     <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            tx_hold_q   <= tx_hold_d;
            bit_cnt_q   <= bit_cnt_d;
            ovf_q       <= ovf_d;
            armed_q     <= armed_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame sequencing: shift, validate length, then write / read / reload.
    always_comb begin
        state_d     = state_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        tx_hold_d   = tx_hold_q;
        bit_cnt_d   = bit_cnt_q;
        ovf_d       = ovf_q;
        armed_d     = armed_q | csn_s;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = '0;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q && !csn_s) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                    ovf_d     = 1'b0;
                    tx_sr_d   = tx_hold_q;
                end
            end
            S_SHIFT: begin
                if (csn_s) begin
                    if (bit_cnt_q == CNT_W'(FRAME_W) && !ovf_q) begin
                        state_d     = S_COMMIT;
                        bus_addr_d  = rx_sr_q[FRAME_W-1 -: ADDR_W];
                        bus_wdata_d = rx_sr_q[DATA_W-1:0];
                        bus_we_d    = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        tx_sr_d     = tx_hold_q;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_sr_d = {rx_sr_q[FRAME_W-2:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(FRAME_W)) begin
                            ovf_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        tx_sr_d = {tx_sr_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            S_COMMIT: begin
                state_d  = S_FETCH;
                bus_re_d = 1'b1;
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                tx_sr_d   = {bus_addr_q, bus_rdata};
                tx_hold_d = {bus_addr_q, bus_rdata};
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_regbus_slave.sv
// Scoreboard bench for spi_regbus_slave with a small register-file model.
`timescale 1ns/1ps
module tb_spi_regbus_slave;

    localparam int HALF = 60;   // SPI half period, ns
    localparam int GAP  = 200;  // cs_n high time between frames, ns

    typedef struct {
        logic        is_we;
        logic [7:0]  addr;
        logic [15:0] data;
    } bus_op_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_miso;
    logic [7:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [15:0] bus_rdata = 16'h0000;
    logic        frame_err;

    logic [15:0] regs [256];
    bus_op_t     exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ferr_seen = 0;
    int          exp_ferr = 0;
    logic        we_prev = 1'b0;
    logic [31:0] exp_tx = 32'h0;

    spi_regbus_slave #(.ADDR_W(8), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .spi_miso  (spi_miso),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .frame_err (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Register file model: address 0x08 is a read-only input bank reading 0x1234.
    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    end

    always @(posedge sys_clk) begin
        if (bus_we && bus_addr != 8'h08) regs[bus_addr] <= bus_wdata;
        if (bus_re) bus_rdata <= (bus_addr == 8'h08) ? 16'h1234 : regs[bus_addr];
    end

    // Bus monitor: every strobe must match the next scoreboard entry.
    always @(negedge sys_clk) begin
        bus_op_t e;
        if (!sys_rst) begin
            if (frame_err) ferr_seen++;
            if (bus_we || bus_re) chk("we_re_excl", {31'b0, bus_we & bus_re}, 32'h0);
            if (bus_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_we", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("we_kind", {31'b0, e.is_we}, 32'h1);
                    chk("we_addr", {24'b0, bus_addr}, {24'b0, e.addr});
                    chk("we_data", {16'b0, bus_wdata}, {16'b0, e.data});
                end
            end
            if (bus_re) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_re", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("re_kind", {31'b0, e.is_we}, 32'h0);
                    chk("re_addr", {24'b0, bus_addr}, {24'b0, e.addr});
                    chk("re_after_we", {31'b0, we_prev}, 32'h1);
                end
            end
            we_prev = bus_we;
        end
    end

    // Drive one frame of nbits (MSB first) and capture MISO before each rising edge.
    task automatic spi_frame(input int nbits, input logic [31:0] word, output logic [31:0] rx);
        rx = 32'h0;
        spi_cs_n = 1'b0;
        #HALF;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            #HALF;
            rx = {rx[30:0], spi_miso};
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #GAP;
    endtask

    task automatic good_frame(input logic [7:0] a, input logic [15:0] d);
        logic [31:0] rx;
        bus_op_t w, r;
        w.is_we = 1'b1; w.addr = a; w.data = d;
        r.is_we = 1'b0; r.addr = a; r.data = 16'h0;
        exp_q.push_back(w);
        exp_q.push_back(r);
        spi_frame(24, {8'h00, a, d}, rx);
        chk("miso_word", {8'h00, rx[23:0]}, exp_tx);
        chk("ops_drained", exp_q.size(), 32'h0);
        chk("no_ferr", ferr_seen, exp_ferr);
        exp_tx = {8'h00, a, (a == 8'h08) ? 16'h1234 : d};
    endtask

    task automatic bad_frame(input int nbits);
        logic [31:0] rx;
        logic [31:0] word;
        int k;
        word = $urandom;
        k = (nbits < 24) ? nbits : 24;
        spi_frame(nbits, word, rx);
        exp_ferr++;
        chk("miso_bad", (rx >> (nbits - k)) & ((32'h1 << k) - 1), exp_tx >> (24 - k));
        chk("ferr_pulse", ferr_seen, exp_ferr);
        chk("no_strobes", exp_q.size(), 32'h0);
    endtask

    initial begin
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_miso",  {31'b0, spi_miso}, 32'h0);
        chk("rst_addr",  {24'b0, bus_addr}, 32'h0);
        chk("rst_wdata", {16'b0, bus_wdata}, 32'h0);
        chk("rst_we",    {31'b0, bus_we}, 32'h0);
        chk("rst_re",    {31'b0, bus_re}, 32'h0);
        chk("rst_ferr",  {31'b0, frame_err}, 32'h0);
        #GAP;

        good_frame(8'h00, 16'hFFFF);   // MISO 0x000000
        good_frame(8'h00, 16'h0000);   // MISO 0x00FFFF
        good_frame(8'h08, 16'h0000);   // MISO 0x000000, readback 0x1234
        bad_frame(20);                 // MISO starts 0x081234
        bad_frame(25);
        good_frame(8'h01, 16'hABCD);   // MISO still 0x081234

        // Reset part way through a frame with cs_n held low.
        spi_cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < 10; i++) begin
            spi_mosi = 1'($urandom);
            #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (4) @(negedge sys_clk);
        chk("midrst_addr", {24'b0, bus_addr}, 32'h0);
        sys_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            spi_mosi = 1'($urandom);
            #HALF; spi_clk = 1'b1; #HALF; spi_clk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #GAP;
        exp_tx = 32'h0;
        chk("midrst_ferr", ferr_seen, exp_ferr);
        chk("midrst_ops", exp_q.size(), 32'h0);

        good_frame(8'h10, 16'hFFFF);   // MISO 0x000000 after reset
        good_frame(8'h10, 16'h5A5A);   // MISO 0x10FFFF

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
